// File: rtl/bcd_subtractor.sv
// bcd_subtractor
//   Digit-serial BCD subtractor. Computes |M - S| for two DIGITS-digit packed
//   BCD operands, one digit per clock, least-significant digit first. A first
//   pass computes M - S. If it ends with a borrow (M < S), the operands are
//   swapped and a second pass computes S - M, and the result is flagged
//   negative.
//
// Handshake: start is sampled only in IDLE. The start edge latches both
//   operands, and busy is high from that edge until DONE. done is a one-cycle
//   pulse in DONE. diff_bcd, neg and err are updated only on entry to DONE and
//   hold their values until the next DONE or reset. start is ignored while
//   busy or done is high.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        operation request (sampled in IDLE)
//   min_bcd      minuend M, digit 0 at [3:0]
//   sub_bcd      subtrahend S, same packing
//   busy         operation in progress
//   done         one-cycle result-valid pulse
//   diff_bcd     |M - S|, packed BCD
//   neg          M < S
//   err          an operand digit was > 9
//   state_dbg_o  current FSM state (0 IDLE, 1 SUB, 2 DONE)
module bcd_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] min_bcd,
  input  logic [4*DIGITS-1:0] sub_bcd,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff_bcd,
  output logic                neg,
  output logic                err,
  output logic [1:0]          state_dbg_o
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic            pass_q, pass_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;

  logic [3:0]      a_dig, b_dig, r_dig;
  logic [4:0]      t;
  logic            bad_operand;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Per-digit subtract. The 5-bit result is negative when bit 4 is set.
  // t is never below -10, so adding 10 to the low nibble yields a valid digit.
  always_comb begin
    a_dig = a_q[idx_q*4 +: 4];
    b_dig = b_q[idx_q*4 +: 4];
    t     = {1'b0, a_dig} - {1'b0, b_dig} - {4'd0, borrow_q};
    r_dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

  // The latched operands are checked in the first SUB cycle. That makes an
  // error take one cycle in SUB before DONE. The operand registers only change
  // by swapping valid digits, so evaluating the check on every SUB cycle is
  // equivalent to checking only the first one.
  assign bad_operand = has_bad_digit(a_q) | has_bad_digit(b_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    pass_d   = pass_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = min_bcd;
          b_d      = sub_bcd;
          idx_d    = '0;
          borrow_d = 1'b0;
          pass_d   = 1'b0;
          state_d  = SUB;
        end
      end
      SUB: begin
        if (bad_operand) begin
          diff_d  = '0;
          neg_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d[idx_q*4 +: 4] = r_dig;
          borrow_d = t[4];
          idx_d    = idx_q + 1'b1;
          if (idx_q == IW'(DIGITS - 1)) begin
            if (t[4] && !pass_q) begin
              // M < S: rerun the subtraction as S - M.
              a_d      = b_q;
              b_d      = a_q;
              pass_d   = 1'b1;
              idx_d    = '0;
              borrow_d = 1'b0;
            end else begin
              diff_d  = r_d;
              neg_d   = pass_q;
              err_d   = 1'b0;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      pass_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      pass_q   <= pass_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign busy        = (state_q == SUB);
  assign done        = (state_q == DONE);
  assign diff_bcd    = diff_q;
  assign neg         = neg_q;
  assign err         = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bcd_subtractor.sv
module tb_bcd_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] min_bcd;
  logic [15:0] sub_bcd;
  logic        busy;
  logic        done;
  logic [15:0] diff_bcd;
  logic        neg;
  logic        err;
  logic [1:0]  state_dbg;

  int n_vec;
  int n_err;

  bcd_subtractor #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .min_bcd    (min_bcd),
    .sub_bcd    (sub_bcd),
    .busy       (busy),
    .done       (done),
    .diff_bcd   (diff_bcd),
    .neg        (neg),
    .err        (err),
    .state_dbg_o(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: start one operation and observe it on falling edges.
  // lat = number of rising edges after the start edge before done is seen
  // (-1 on timeout). bc = cycles with busy high. With hold=1, start is kept
  // high until done is observed.
  task automatic run_op(input logic [15:0] m, input logic [15:0] s, input logic hold,
                        output int lat, output int bc);
    lat = -1;
    bc  = 0;
    @(negedge clk);
    min_bcd = m;
    sub_bcd = s;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      // Operand inputs may change freely after the start edge.
      min_bcd = 16'h9999;
      sub_bcd = 16'h0000;
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [15:0] exp_diff, input logic exp_neg,
                              input logic exp_err);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (diff_bcd !== exp_diff) begin
      n_err++;
      $display("FAIL %s diff_bcd: got %h expected %h", name, diff_bcd, exp_diff);
    end
    n_vec++;
    if (neg !== exp_neg) begin
      n_err++;
      $display("FAIL %s neg: got %b expected %b", name, neg, exp_neg);
    end
    n_vec++;
    if (err !== exp_err) begin
      n_err++;
      $display("FAIL %s err: got %b expected %b", name, err, exp_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    min_bcd = '0;
    sub_bcd = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, neg, err, diff_bcd, state_dbg} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b neg=%b err=%b diff=%h st=%0d expected all 0",
               busy, done, neg, err, diff_bcd, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_positive;
    int lat, bc;
    run_op(16'h0345, 16'h0127, 1'b0, lat, bc);
    check_result("pos_0345_0127", lat, 4, 16'h0218, 1'b0, 1'b0);
    n_vec++;
    if (bc !== 4) begin
      n_err++;
      $display("FAIL pos_busy_cycles: got %0d expected %0d", bc, 4);
    end
  endtask

  task automatic test_negative;
    int lat, bc;
    run_op(16'h0100, 16'h0250, 1'b0, lat, bc);
    check_result("neg_0100_0250", lat, 8, 16'h0150, 1'b1, 1'b0);
    n_vec++;
    if (bc !== 8) begin
      n_err++;
      $display("FAIL neg_busy_cycles: got %0d expected %0d", bc, 8);
    end
    run_op(16'h0000, 16'h9999, 1'b0, lat, bc);
    check_result("neg_0000_9999", lat, 8, 16'h9999, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    run_op(16'h9999, 16'h9999, 1'b0, lat, bc);
    check_result("b2b_equal", lat, 4, 16'h0000, 1'b0, 1'b0);
    // run_op drives start on the next falling edge, which falls in IDLE.
    run_op(16'h0000, 16'h0001, 1'b0, lat, bc);
    check_result("b2b_0000_0001", lat, 8, 16'h0001, 1'b1, 1'b0);
  endtask

  task automatic test_error;
    int lat, bc;
    run_op(16'h12A4, 16'h0003, 1'b0, lat, bc);
    check_result("err_12A4", lat, 1, 16'h0000, 1'b0, 1'b1);
    run_op(16'h0050, 16'h0020, 1'b0, lat, bc);
    check_result("err_cleared", lat, 4, 16'h0030, 1'b0, 1'b0);
  endtask

  task automatic test_start_held;
    int lat, bc, extra_done, extra_busy;
    run_op(16'h5000, 16'h0001, 1'b1, lat, bc);
    check_result("held_5000_0001", lat, 4, 16'h4999, 1'b0, 1'b0);
    extra_done = 0;
    extra_busy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    n_vec++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      n_err++;
      $display("FAIL held_single_op: got extra done=%0d busy=%0d expected 0/0",
               extra_done, extra_busy);
    end
  endtask

  task automatic test_reset_midop;
    int lat, bc, dcnt;
    @(negedge clk);
    min_bcd = 16'h0010;
    sub_bcd = 16'h0020;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, neg, err, diff_bcd, state_dbg} !== 22'd0) begin
      n_err++;
      $display("FAIL midop_reset_outputs: got busy=%b done=%b neg=%b err=%b diff=%h st=%0d expected all 0",
               busy, done, neg, err, diff_bcd, state_dbg);
    end
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_vec++;
    if (dcnt !== 0) begin
      n_err++;
      $display("FAIL midop_no_done: got %0d active cycles expected 0", dcnt);
    end
    run_op(16'h0020, 16'h0010, 1'b0, lat, bc);
    check_result("after_reset_0020_0010", lat, 4, 16'h0010, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_positive();
    test_negative();
    test_back_to_back();
    test_error();
    test_start_held();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
